rsa_host_responder: RTL and testbench

//  FPGA-side responder for the ARM<->FPGA command/data protocol. Accepts 32-bit commands,

---
 rtl/rsa_host_responder.sv | 195 +++++++++++++++++++
 tb/tb_rsa_host_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_host_responder.sv
// ARM<->FPGA command responder: collects operands, launches the exponentiation or
// Montgomery core, returns its result, and closes every command with done/done_read.
module rsa_host_responder #(
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned CMD_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CMD_W-1:0]  arm_to_fpga_cmd,
  input  logic              arm_to_fpga_cmd_valid,
  output logic              fpga_to_arm_done,
  input  logic              fpga_to_arm_done_read,
  input  logic              arm_to_fpga_data_valid,
  output logic              arm_to_fpga_data_ready,
  input  logic [DATA_W-1:0] arm_to_fpga_data,
  output logic              fpga_to_arm_data_valid,
  input  logic              fpga_to_arm_data_ready,
  output logic [DATA_W-1:0] fpga_to_arm_data,
  output logic              core_start,
  output logic              core_mode,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [DATA_W-1:0] op_mod,
  output logic [DATA_W-1:0] op_rsq,
  output logic [DATA_W-1:0] op_exp,
  output logic [3:0]        leds
);

  localparam int unsigned CODE_W = 3;
  localparam int unsigned ST_W   = 3;

  localparam logic [CODE_W-1:0] CMD_COMPUTE_EXP  = 3'd0;
  localparam logic [CODE_W-1:0] CMD_COMPUTE_MONT = 3'd1;
  localparam logic [CODE_W-1:0] CMD_READ_MOD     = 3'd2;
  localparam logic [CODE_W-1:0] CMD_READ_RSQ     = 3'd3;
  localparam logic [CODE_W-1:0] CMD_READ_EXP     = 3'd4;
  localparam logic [CODE_W-1:0] CMD_WRITE        = 3'd5;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RX        = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_TX        = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic [CODE_W-1:0] cmd_q, cmd_d;
  logic              bad_q, bad_d;

  logic data_ready_q, data_ready_d;
  logic out_valid_q, out_valid_d;
  logic done_q, done_d;
  logic core_start_q, core_start_d;
  logic core_mode_q, core_mode_d;

  logic [DATA_W-1:0] op_mod_q, op_rsq_q, op_exp_q, res_q;
  logic              wr_mod, wr_rsq, wr_exp, wr_res;

  logic [CODE_W-1:0] cmd_code;
  logic              unused_cmd_hi;

  // Only the low command bits carry meaning; the rest of the word is don't-care.
  assign cmd_code      = arm_to_fpga_cmd[CODE_W-1:0];
  assign unused_cmd_hi = ^arm_to_fpga_cmd[CMD_W-1:CODE_W];

  // State, latched command and sticky bad-command flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state and datapath write enables.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    bad_d   = bad_q;
    wr_mod  = 1'b0;
    wr_rsq  = 1'b0;
    wr_exp  = 1'b0;
    wr_res  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arm_to_fpga_cmd_valid) begin
          cmd_d = cmd_code;
          case (cmd_code)
            CMD_READ_MOD, CMD_READ_RSQ, CMD_READ_EXP: state_d = ST_RX;
            CMD_COMPUTE_EXP, CMD_COMPUTE_MONT:        state_d = ST_START;
            CMD_WRITE:                                state_d = ST_TX;
            default: begin
              state_d = ST_DONE;
              bad_d   = 1'b1;
            end
          endcase
        end
      end
      ST_RX: begin
        if (arm_to_fpga_data_valid) begin
          state_d = ST_DONE;
          case (cmd_q)
            CMD_READ_MOD: wr_mod = 1'b1;
            CMD_READ_RSQ: wr_rsq = 1'b1;
            CMD_READ_EXP: wr_exp = 1'b1;
            default:      ;
          endcase
        end
      end
      ST_START: state_d = ST_WAIT_CORE;
      ST_WAIT_CORE: begin
        if (core_done) begin
          wr_res  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_TX: begin
        if (fpga_to_arm_data_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (fpga_to_arm_done_read) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state so they leave a flop.
  always_comb begin
    data_ready_d = 1'b0;
    out_valid_d  = 1'b0;
    done_d       = 1'b0;
    core_start_d = 1'b0;
    core_mode_d  = 1'b0;
    unique case (state_d)
      ST_RX: data_ready_d = 1'b1;
      ST_START: begin
        core_start_d = 1'b1;
        core_mode_d  = cmd_d[0];
      end
      ST_WAIT_CORE: core_mode_d = cmd_d[0];
      ST_TX:        out_valid_d = 1'b1;
      ST_DONE:      done_d      = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      core_mode_q  <= 1'b0;
    end else begin
      data_ready_q <= data_ready_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
      core_mode_q  <= core_mode_d;
    end
  end

  // Operand and result registers; contents are lost on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_mod_q <= '0;
      op_rsq_q <= '0;
      op_exp_q <= '0;
      res_q    <= '0;
    end else begin
      if (wr_mod) op_mod_q <= arm_to_fpga_data;
      if (wr_rsq) op_rsq_q <= arm_to_fpga_data;
      if (wr_exp) op_exp_q <= arm_to_fpga_data;
      if (wr_res) res_q    <= core_result;
    end
  end

  assign arm_to_fpga_data_ready = data_ready_q;
  assign fpga_to_arm_data_valid = out_valid_q;
  assign fpga_to_arm_done       = done_q;
  assign fpga_to_arm_data       = res_q;
  assign core_start             = core_start_q;
  assign core_mode              = core_mode_q;
  assign op_mod                 = op_mod_q;
  assign op_rsq                 = op_rsq_q;
  assign op_exp                 = op_exp_q;
  assign leds                   = {bad_q, ST_W'(state_q)};

endmodule

// File: tb/tb_rsa_host_responder.sv
// Scoreboard bench for rsa_host_responder: a command-level model pushes expectations,
// a negedge monitor pops them whenever the DUT presents start, result or done.
module tb_rsa_host_responder;

  localparam int unsigned DATA_W = 1024;
  localparam int unsigned CMD_W  = 32;
  localparam int          BUDGET = 200;

  logic              clk = 1'b0;
  logic              resetn;
  logic [CMD_W-1:0]  arm_to_fpga_cmd;
  logic              arm_to_fpga_cmd_valid;
  logic              fpga_to_arm_done;
  logic              fpga_to_arm_done_read;
  logic              arm_to_fpga_data_valid;
  logic              arm_to_fpga_data_ready;
  logic [DATA_W-1:0] arm_to_fpga_data;
  logic              fpga_to_arm_data_valid;
  logic              fpga_to_arm_data_ready;
  logic [DATA_W-1:0] fpga_to_arm_data;
  logic              core_start;
  logic              core_mode;
  logic              core_done;
  logic [DATA_W-1:0] core_result;
  logic [DATA_W-1:0] op_mod, op_rsq, op_exp;
  logic [3:0]        leds;

  rsa_host_responder #(.DATA_W(DATA_W), .CMD_W(CMD_W)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .arm_to_fpga_cmd        (arm_to_fpga_cmd),
    .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
    .fpga_to_arm_done       (fpga_to_arm_done),
    .fpga_to_arm_done_read  (fpga_to_arm_done_read),
    .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
    .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
    .arm_to_fpga_data       (arm_to_fpga_data),
    .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
    .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
    .fpga_to_arm_data       (fpga_to_arm_data),
    .core_start             (core_start),
    .core_mode              (core_mode),
    .core_done              (core_done),
    .core_result            (core_result),
    .op_mod                 (op_mod),
    .op_rsq                 (op_rsq),
    .op_exp                 (op_exp),
    .leds                   (leds)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic chkb(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Command-level reference state.
  typedef struct {
    logic [DATA_W-1:0] mod_v;
    logic [DATA_W-1:0] rsq_v;
    logic [DATA_W-1:0] exp_v;
    bit                bad;
  } done_exp_t;

  logic [DATA_W-1:0] m_mod, m_rsq, m_exp, m_res;
  bit                m_bad;
  done_exp_t         exp_done_q[$];
  bit                exp_start_q[$];
  logic [DATA_W-1:0] exp_res_q[$];

  // Stand-in core arithmetic; distinct per mode so a wrong mode shows in the result.
  function automatic logic [DATA_W-1:0] core_fn(input bit mode, input logic [DATA_W-1:0] m,
                                                input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] e);
    return mode ? (m ^ r ^ e) : (m + e);
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(DATA_W / 32); i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Core model: result core_lat cycles after the start pulse; optional stray done pulses when idle.
  int core_lat = 3;
  int core_cnt = 0;
  bit core_busy = 1'b0;
  bit core_fired = 1'b0;
  bit spur_en = 1'b0;

  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (!resetn) begin
        core_busy = 1'b0;
      end else begin
        if (core_busy) begin
          if (core_cnt == 0) begin
            core_done   = 1'b1;
            core_result = core_fn(core_mode, op_mod, op_rsq, op_exp);
            core_busy   = 1'b0;
            core_fired  = 1'b1;
          end else begin
            core_cnt--;
          end
        end else if (spur_en && $urandom_range(0, 5) == 0) begin
          core_done   = 1'b1;
          core_result = rand_data();
        end
        if (core_start) begin
          core_busy = 1'b1;
          core_cnt  = core_lat;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  bit        prev_start = 1'b0;
  bit        prev_done  = 1'b0;
  done_exp_t mon_e;
  bit        mon_mode;

  always @(negedge clk) begin
    if (!resetn) begin
      prev_start = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (core_start) begin
        chkb("core_start single cycle", 32'(prev_start), 0);
        chkb("core_start expected", 32'(exp_start_q.size() != 0), 1);
        if (exp_start_q.size() != 0) begin
          mon_mode = exp_start_q.pop_front();
          chkb("core_mode", 32'(core_mode), 32'(mon_mode));
        end
      end
      if (fpga_to_arm_data_valid && fpga_to_arm_data_ready) begin
        chkb("result expected", 32'(exp_res_q.size() != 0), 1);
        if (exp_res_q.size() != 0) chk("result data", fpga_to_arm_data, exp_res_q.pop_front());
      end
      if (fpga_to_arm_done && !prev_done) begin
        chkb("done expected", 32'(exp_done_q.size() != 0), 1);
        if (exp_done_q.size() != 0) begin
          mon_e = exp_done_q.pop_front();
          chk("op_mod", op_mod, mon_e.mod_v);
          chk("op_rsq", op_rsq, mon_e.rsq_v);
          chk("op_exp", op_exp, mon_e.exp_v);
          chkb("bad flag", 32'(leds[3]), 32'(mon_e.bad));
        end
      end
      prev_start = core_start;
      prev_done  = fpga_to_arm_done;
    end
  end

  task automatic check_all_zero(input string tag);
    chkb({tag, " done"}, 32'(fpga_to_arm_done), 0);
    chkb({tag, " data_ready"}, 32'(arm_to_fpga_data_ready), 0);
    chkb({tag, " data_valid"}, 32'(fpga_to_arm_data_valid), 0);
    chkb({tag, " core_start"}, 32'(core_start), 0);
    chkb({tag, " core_mode"}, 32'(core_mode), 0);
    chkb({tag, " leds"}, 32'(leds), 0);
    chk({tag, " op_mod"}, op_mod, '0);
    chk({tag, " op_rsq"}, op_rsq, '0);
    chk({tag, " op_exp"}, op_exp, '0);
    chk({tag, " result"}, fpga_to_arm_data, '0);
  endtask

  // Asynchronous reset mid-cycle; the model and scoreboard lose everything too.
  task automatic abort_reset();
    #2;
    resetn = 1'b0;
    exp_done_q.delete();
    exp_start_q.delete();
    exp_res_q.delete();
    m_mod = '0; m_rsq = '0; m_exp = '0; m_res = '0; m_bad = 1'b0;
    arm_to_fpga_cmd_valid  = 1'b0;
    arm_to_fpga_data_valid = 1'b0;
    fpga_to_arm_data_ready = 1'b0;
    fpga_to_arm_done_read  = 1'b0;
    #1;
    check_all_zero("async reset");
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One full command: model update, drive, bounded wait for done, done_read handshake.
  task automatic do_cmd(input logic [2:0] code, input logic [DATA_W-1:0] data, input int dly,
                        input int dr_dly, input bit noise, input bit dr_cmd, input int abort_at);
    int        cyc;
    bit        is_rx, is_tx, is_comp;
    done_exp_t e;
    is_rx   = (code == 3'd2) || (code == 3'd3) || (code == 3'd4);
    is_tx   = (code == 3'd5);
    is_comp = (code <= 3'd1);
    case (code)
      3'd2: m_mod = data;
      3'd3: m_rsq = data;
      3'd4: m_exp = data;
      3'd0, 3'd1: begin
        exp_start_q.push_back(code[0]);
        m_res = core_fn(code[0], m_mod, m_rsq, m_exp);
      end
      3'd5: exp_res_q.push_back(m_res);
      default: m_bad = 1'b1;
    endcase
    e.mod_v = m_mod; e.rsq_v = m_rsq; e.exp_v = m_exp; e.bad = m_bad;
    exp_done_q.push_back(e);
    core_fired       = 1'b0;
    arm_to_fpga_data = data;
    if (dly == 0) begin
      if (is_rx) arm_to_fpga_data_valid = 1'b1;
      if (is_tx) fpga_to_arm_data_ready = 1'b1;
    end
    arm_to_fpga_cmd       = CMD_W'({$urandom(), code});
    arm_to_fpga_cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    arm_to_fpga_cmd_valid = 1'b0;
    cyc = 1;
    while (!fpga_to_arm_done && cyc < BUDGET) begin
      if (abort_at != 0 && cyc == abort_at) begin
        abort_reset();
        return;
      end
      if (cyc > dly) begin
        if (is_rx) arm_to_fpga_data_valid = 1'b1;
        if (is_tx) fpga_to_arm_data_ready = 1'b1;
      end else begin
        if (is_rx) chkb("data_ready while waiting", 32'(arm_to_fpga_data_ready), 1);
        if (is_tx) chkb("result valid while waiting", 32'(fpga_to_arm_data_valid), 1);
      end
      if (noise && $urandom_range(0, 2) == 0) begin
        arm_to_fpga_cmd       = CMD_W'($urandom());
        arm_to_fpga_cmd_valid = 1'b1;
      end else begin
        arm_to_fpga_cmd_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    arm_to_fpga_cmd_valid = 1'b0;
    chkb("done within budget", 32'(fpga_to_arm_done), 1);
    if (!fpga_to_arm_done) begin
      abort_reset();
      return;
    end
    if ((is_rx || is_tx) && dly == 0) chkb("min latency", 32'(cyc), 2);
    if (!is_rx && !is_tx && !is_comp) chkb("illegal reaches done in 2", 32'(cyc <= 2), 1);
    if (is_comp) begin
      chkb("done after core_done", 32'(core_fired), 1);
      chkb("compute latency", 32'(cyc), 32'(3 + core_lat));
    end
    chkb("handshakes low in done", 32'({arm_to_fpga_data_ready, fpga_to_arm_data_valid}), 0);
    arm_to_fpga_data_valid = 1'b0;
    fpga_to_arm_data_ready = 1'b0;
    repeat (dr_dly) begin
      @(posedge clk);
      #1;
      chkb("done held", 32'(fpga_to_arm_done), 1);
    end
    fpga_to_arm_done_read = 1'b1;
    if (dr_cmd) begin
      arm_to_fpga_cmd       = CMD_W'($urandom_range(0, 7));
      arm_to_fpga_cmd_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    fpga_to_arm_done_read = 1'b0;
    arm_to_fpga_cmd_valid = 1'b0;
    chkb("done cleared", 32'(fpga_to_arm_done), 0);
    chkb("state back to idle", 32'(leds[2:0]), 0);
  endtask

  logic [DATA_W-1:0] d;

  initial begin
    resetn                 = 1'b1;
    arm_to_fpga_cmd        = '0;
    arm_to_fpga_cmd_valid  = 1'b0;
    fpga_to_arm_done_read  = 1'b0;
    arm_to_fpga_data_valid = 1'b0;
    arm_to_fpga_data       = '0;
    fpga_to_arm_data_ready = 1'b0;
    m_mod = '0; m_rsq = '0; m_exp = '0; m_res = '0; m_bad = 1'b0;
    #2 resetn = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    // READ_MOD with valid already up, then with valid held back.
    d = rand_data(); d[DATA_W-1 -: 16] = 16'hC395; d[7:0] = 8'h3F;
    do_cmd(3'd2, d, 0, 2, 1'b0, 1'b0, 0);
    d = rand_data(); d[DATA_W-1 -: 16] = 16'hC395; d[7:0] = 8'h3F;
    do_cmd(3'd2, d, 3, 0, 1'b0, 1'b0, 0);

    // Operands then Montgomery with a 20-cycle core, result read back.
    core_lat = 20;
    do_cmd(3'd3, rand_data(), 0, 0, 1'b0, 1'b0, 0);
    do_cmd(3'd4, rand_data(), 1, 0, 1'b0, 1'b0, 0);
    do_cmd(3'd2, rand_data(), 2, 0, 1'b0, 1'b0, 0);
    do_cmd(3'd1, rand_data(), 0, 1, 1'b0, 1'b0, 0);
    do_cmd(3'd5, rand_data(), 0, 0, 1'b0, 1'b0, 0);

    // Exponentiation with small exponent and fixed-pattern modulus; repeated WRITE.
    core_lat = 5;
    d = '0; d[7:0] = 8'haf;
    do_cmd(3'd4, d, 0, 0, 1'b0, 1'b0, 0);
    d = rand_data(); d[DATA_W-1 -: 16] = 16'hd97a; d[7:0] = 8'h85;
    do_cmd(3'd2, d, 0, 0, 1'b0, 1'b0, 0);
    do_cmd(3'd0, rand_data(), 0, 0, 1'b0, 1'b0, 0);
    do_cmd(3'd5, rand_data(), 0, 0, 1'b0, 1'b0, 0);
    do_cmd(3'd5, rand_data(), 2, 0, 1'b0, 1'b1, 0);

    // Illegal command.
    do_cmd(3'd7, rand_data(), 0, 1, 1'b0, 1'b0, 0);

    // Slow ARM with stray command strobes while busy.
    do_cmd(3'd3, rand_data(), 5, 0, 1'b1, 1'b0, 0);
    do_cmd(3'd5, rand_data(), 5, 0, 1'b1, 1'b0, 0);
    do_cmd(3'd1, rand_data(), 0, 0, 1'b1, 1'b1, 0);

    // Reset while waiting on the core, then normal operation again.
    core_lat = 20;
    do_cmd(3'd0, rand_data(), 0, 0, 1'b0, 1'b0, 8);
    core_lat = 2;
    do_cmd(3'd2, rand_data(), 0, 0, 1'b0, 1'b0, 0);
    do_cmd(3'd5, rand_data(), 0, 0, 1'b0, 1'b0, 0);

    // Randomized traffic with stray core_done pulses.
    spur_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      core_lat = $urandom_range(0, 12);
      do_cmd(3'($urandom_range(0, 7)), rand_data(), $urandom_range(0, 5), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    spur_en = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chkb("scoreboard drained", 32'(exp_done_q.size() + exp_start_q.size() + exp_res_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
